// File: rtl/temp_alarm_pkg.sv
// -----------------------------------------------------------------------------
// temp_alarm_pkg
// Shared definitions for the temperature alarm controller and the buzzer stage.
//   - SEL_* : 2-bit code consumed by the buzzer (11 = buzzer active)
//   - ST_*  : controller state encoding
//   - alarm_out_t / state_to_out : Moore decode of a state into sel/fault
// -----------------------------------------------------------------------------
package temp_alarm_pkg;

  localparam logic [1:0] SEL_NORMAL = 2'b00;
  localparam logic [1:0] SEL_WARN   = 2'b01;
  localparam logic [1:0] SEL_MUTED  = 2'b10;
  localparam logic [1:0] SEL_ALARM  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_NORMAL = 3'd0;
  localparam state_t ST_WARN   = 3'd1;
  localparam state_t ST_MUTED  = 3'd2;
  localparam state_t ST_ALARM  = 3'd3;
  localparam state_t ST_FAULT  = 3'd4;

  typedef struct packed {
    logic [1:0] sel;
    logic       fault;
  } alarm_out_t;

  // FAULT shares the alarm code so the buzzer sounds on a dead sensor.
  function automatic alarm_out_t state_to_out(input state_t s);
    alarm_out_t o;
    o.fault = 1'b0;
    case (s)
      ST_NORMAL: o.sel = SEL_NORMAL;
      ST_WARN:   o.sel = SEL_WARN;
      ST_MUTED:  o.sel = SEL_MUTED;
      ST_ALARM:  o.sel = SEL_ALARM;
      default: begin
        o.sel   = SEL_ALARM;
        o.fault = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/temp_alarm_ctrl_if.sv
// -----------------------------------------------------------------------------
// temp_alarm_if
// Bundles the sample stream, the user acknowledge and the buzzer-facing outputs.
//   data[7:0]   sample: data[6:0] whole degC, data[7] adds 0.5 degC
//   data_valid  one-cycle strobe qualifying data
//   ack         one-cycle debounced button pulse
//   sel[1:0]    buzzer code (00 normal, 01 warn, 10 muted, 11 alarm/fault)
//   fault       high while the sensor is considered dead
// master: sample source / button side.  slave: the controller.
// -----------------------------------------------------------------------------
interface temp_alarm_if;
  import temp_alarm_pkg::*;

  logic [7:0] data;
  logic       data_valid;
  logic       ack;
  logic [1:0] sel;
  logic       fault;

  modport master (
    output data,
    output data_valid,
    output ack,
    input  sel,
    input  fault
  );

  modport slave (
    input  data,
    input  data_valid,
    input  ack,
    output sel,
    output fault
  );

endinterface

// File: rtl/temp_alarm_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// sensor_watchdog
// Counts clock cycles since the last kick; expired is a level that stays high
// while the count is saturated at TIMEOUT.
//   clk      system clock
//   rst_n    asynchronous active-low reset (count returns to 0)
//   kick     clears the count (driven by data_valid)
//   expired  high while count == TIMEOUT
// -----------------------------------------------------------------------------
module sensor_watchdog #(
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic expired
);

  localparam logic [26:0] LIMIT = 27'(TIMEOUT);

  logic [26:0] cnt_q;
  logic [26:0] cnt_d;

  // Saturate at LIMIT so expired holds until the next kick.
  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 27'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/temp_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// temp_alarm_ctrl
// Classifies temperature samples into NORMAL / WARN / ALARM with hysteresis and
// CONFIRM-sample confirmation, supports muting via ack, and enters FAULT when
// the sensor goes silent for TIMEOUT cycles.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    temp_alarm_if.slave: data, data_valid, ack in; sel, fault out
// sel/fault are registered from the next state, so they change on the same
// edge as the state register (one cycle after the deciding sample).
// -----------------------------------------------------------------------------
module temp_alarm_ctrl
  import temp_alarm_pkg::*;
#(
  parameter int unsigned WARN_T  = 40,
  parameter int unsigned ALARM_T = 50,
  parameter int unsigned HYST    = 4,
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic          clk,
  input  logic          rst_n,
  temp_alarm_if.slave   bus
);

  // Thresholds in half-degree units, widened to 9 bits so 2*127 fits.
  localparam logic [8:0] W2_V       = 9'(2 * WARN_T);
  localparam logic [8:0] A2_V       = 9'(2 * ALARM_T);
  localparam logic [8:0] WARN_LO_V  = 9'(2 * WARN_T - HYST);
  localparam logic [8:0] ALARM_LO_V = 9'(2 * ALARM_T - HYST);
  localparam logic [3:0] CONF_V     = 4'(CONFIRM);

  state_t     state_q, state_d;
  logic [3:0] up_q, up_d;
  logic [3:0] dn_q, dn_d;
  alarm_out_t out_q;
  alarm_out_t out_d;

  logic [8:0] t;
  logic       up_qual;
  logic       dn_qual;
  logic       wd_expired;

  sensor_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (bus.data_valid),
    .expired (wd_expired)
  );

  // Half-degree bit moves to the LSB so t is a plain unsigned value.
  assign t = {1'b0, bus.data[6:0], bus.data[7]};

  // Which direction each counter tracks depends on the current level.
  always_comb begin
    up_qual = 1'b0;
    dn_qual = 1'b0;
    case (state_q)
      ST_NORMAL: up_qual = (t >= W2_V);
      ST_WARN: begin
        up_qual = (t >= A2_V);
        dn_qual = (t < WARN_LO_V);
      end
      ST_ALARM, ST_MUTED: dn_qual = (t < ALARM_LO_V);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    dn_d    = dn_q;

    if (bus.data_valid) begin
      // A sample always beats a simultaneous watchdog expiry.
      up_d = up_qual ? (up_q + 4'd1) : 4'd0;
      dn_d = dn_qual ? (dn_q + 4'd1) : 4'd0;
      if (state_q == ST_FAULT) begin
        state_d = ST_NORMAL;
      end else if ((state_q == ST_ALARM) && bus.ack) begin
        // Mute takes priority over a confirmed de-escalation.
        state_d = ST_MUTED;
      end else if (up_d == CONF_V) begin
        state_d = (state_q == ST_NORMAL) ? ST_WARN : ST_ALARM;
      end else if (dn_d == CONF_V) begin
        state_d = (state_q == ST_WARN) ? ST_NORMAL : ST_WARN;
      end
    end else if (wd_expired) begin
      state_d = ST_FAULT;
    end else if ((state_q == ST_ALARM) && bus.ack) begin
      state_d = ST_MUTED;
    end

    // Counts never carry across a level change or into/through FAULT.
    if ((state_d != state_q) || (!bus.data_valid && wd_expired)) begin
      up_d = 4'd0;
      dn_d = 4'd0;
    end
  end

  assign out_d = state_to_out(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      up_q    <= 4'd0;
      dn_q    <= 4'd0;
      out_q   <= state_to_out(ST_NORMAL);
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      out_q   <= out_d;
    end
  end

  assign bus.sel   = out_q.sel;
  assign bus.fault = out_q.fault;

endmodule
